// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one memory read per instruction, holds the result for the decoder.
// Latency: request pulse, then >=1 cycle memory wait, instr_valid rises the cycle after the response (3 cycles/instr best case).
// Backpressure: the instruction is held stable in HOLD while instr_ready=0; no further reads are issued until it is accepted.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(1)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_read_req,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   input  logic                  mem_read_valid,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect_en,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ADDR_WIDTH-1:0] pc_value
);

   // REQ: pulse a read; WAIT: expect our response; HOLD: present instr;
   // DRAIN: a redirect orphaned a read, swallow its response before issuing again.
   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [DATA_WIDTH-1:0]   instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
   logic                    instr_valid_q, instr_valid_d;

   // Next-state and datapath: normal fetch sequencing, then redirect overrides everything.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;

      case (state_q)
         REQ: begin
            // Any response seen here is unsolicited; the read we just issued cannot return yet.
            state_d = WAIT;
         end
         WAIT: begin
            if (mem_read_valid) begin
               instr_d       = mem_read_data;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               instr_valid_d = 1'b0;
               pc_d          = pc_q + PC_STEP;
               state_d       = REQ;
            end
         end
         DRAIN: begin
            if (mem_read_valid) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase

      if (redirect_en) begin
         // Whatever was captured or held is from the old stream; drop it.
         pc_d          = redirect_pc;
         instr_d       = instr_q;
         instr_pc_d    = instr_pc_q;
         instr_valid_d = 1'b0;
         if (state_q == HOLD) begin
            state_d = REQ;
         end else if (state_q != REQ && mem_read_valid) begin
            // The outstanding read completes this very cycle, so nothing is left to drain.
            state_d = REQ;
         end else begin
            // REQ still sends its pulse, so a stale response is always owed after this.
            state_d = DRAIN;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= REQ;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // The request is gated by rst so no read escapes while the memory is being reset with us.
   assign mem_read_req     = (state_q == REQ) && !rst;
   assign mem_read_address = pc_q;
   assign instr            = instr_q;
   assign instr_pc         = instr_pc_q;
   assign instr_valid      = instr_valid_q;
   assign pc_value         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset/stream/backpressure vector table, hand-written redirect,
// collision, reset and wrap sequences, then randomized traffic against a program-order model.
module tb_fetch_unit;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_ready;
   logic          redirect_en;
   logic [AW-1:0] redirect_pc;

   // Main DUT (RESET_PC = 0)
   logic          m0_req;
   logic [AW-1:0] m0_addr;
   logic          m0_vld;
   logic [DW-1:0] m0_dat;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic [AW-1:0] pc_value;

   // Wrap DUT (RESET_PC = all ones), never redirected
   logic          w_redir;
   logic          m1_req;
   logic [AW-1:0] m1_addr;
   logic          m1_vld;
   logic [DW-1:0] m1_dat;
   logic [DW-1:0] w_instr;
   logic [AW-1:0] w_instr_pc;
   logic          w_instr_valid;
   logic [AW-1:0] w_pc_value;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0), .PC_STEP(32'h1)) dut (
      .clk(clk), .rst(rst),
      .mem_read_req(m0_req), .mem_read_address(m0_addr),
      .mem_read_valid(m0_vld), .mem_read_data(m0_dat),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .pc_value(pc_value)
   );

   fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'hFFFF_FFFF), .PC_STEP(32'h1)) dut_w (
      .clk(clk), .rst(rst),
      .mem_read_req(m1_req), .mem_read_address(m1_addr),
      .mem_read_valid(m1_vld), .mem_read_data(m1_dat),
      .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(instr_ready),
      .redirect_en(w_redir), .redirect_pc(redirect_pc), .pc_value(w_pc_value)
   );

   int nvec = 0;
   int nerr = 0;

   // Memory contents: every word holds 0xA0 + its address
   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return a + 32'hA0;
   endfunction

   // ---------------- memory model ----------------
   int            lat;
   bit            rand_lat;
   bit            spur_en;
   int            mcnt [2];
   logic [AW-1:0] mra  [2];

   task automatic mem_step(input logic req, input logic [AW-1:0] addr,
                           inout int cnt, inout logic [AW-1:0] ra,
                           output logic v, output logic [DW-1:0] d);
      v = 1'b0;
      d = 32'hDEAD_BEEF;
      if (rst) begin
         cnt = 0;
      end else begin
         if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               v = 1'b1;
               d = memf(ra);
            end
         end else if (spur_en && $urandom_range(0, 7) == 0) begin
            v = 1'b1;
         end
         if (req) begin
            cnt = rand_lat ? int'($urandom_range(1, 4)) : lat;
            ra  = addr;
         end
      end
   endtask

   initial begin
      m0_vld = 1'b0; m0_dat = '0; m1_vld = 1'b0; m1_dat = '0;
      mcnt[0] = 0; mcnt[1] = 0; mra[0] = '0; mra[1] = '0;
      forever begin
         @(negedge clk);
         mem_step(m0_req, m0_addr, mcnt[0], mra[0], m0_vld, m0_dat);
         mem_step(m1_req, m1_addr, mcnt[1], mra[1], m1_vld, m1_dat);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!instr_valid && n < budget) begin
         tick();
         #1;
         n++;
      end
      check({name, "_timeout"}, instr_valid, 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          rst;
      logic          rdy;
      logic          e_req;
      logic [AW-1:0] e_addr;
      logic          e_vld;
      logic          chk_dat;
      logic [DW-1:0] e_instr;
      logic [AW-1:0] e_ipc;
      logic [AW-1:0] e_pc;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input logic r, input logic rdy, input logic req, input logic [AW-1:0] addr,
                      input logic vld, input logic chk, input logic [DW-1:0] ins,
                      input logic [AW-1:0] ipc, input logic [AW-1:0] pc);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.e_req = req; v.e_addr = addr; v.e_vld = vld;
      v.chk_dat = chk; v.e_instr = ins; v.e_ipc = ipc; v.e_pc = pc;
      tbl.push_back(v);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main ----------------
   initial begin
      logic [AW-1:0] exp_pc;
      bit            prev_kill;
      int            accepted;
      int            n;

      rst = 1'b1; instr_ready = 1'b1; redirect_en = 1'b0; redirect_pc = '0; w_redir = 1'b0;
      lat = 1; rand_lat = 1'b0; spur_en = 1'b0;

      // reset (2 cycles), streaming with 1-cycle memory, then 5 cycles of backpressure
      //   rst rdy req addr vld chk instr  ipc pc
      add(1, 1, 0, 0, 0, 1, 32'h0,  0, 0);
      add(0, 1, 1, 0, 0, 0, 32'h0,  0, 0);
      add(0, 1, 0, 0, 0, 0, 32'h0,  0, 0);
      add(0, 1, 0, 0, 1, 1, 32'hA0, 0, 0);
      add(0, 1, 1, 1, 0, 0, 32'h0,  0, 1);
      add(0, 1, 0, 0, 0, 0, 32'h0,  0, 1);
      add(0, 1, 0, 0, 1, 1, 32'hA1, 1, 1);
      add(0, 1, 1, 2, 0, 0, 32'h0,  0, 2);
      add(0, 1, 0, 0, 0, 0, 32'h0,  0, 2);
      for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 1, 1, 32'hA2, 2, 2);
      add(0, 1, 0, 0, 1, 1, 32'hA2, 2, 2);
      add(0, 1, 1, 3, 0, 0, 32'h0,  0, 3);

      tick();
      for (int i = 0; i < tbl.size(); i++) begin
         if (i > 0) tick();
         rst = tbl[i].rst;
         instr_ready = tbl[i].rdy;
         #1;
         check($sformatf("row%0d_req", i), m0_req, tbl[i].e_req);
         check($sformatf("row%0d_valid", i), instr_valid, tbl[i].e_vld);
         check($sformatf("row%0d_pc", i), pc_value, tbl[i].e_pc);
         if (tbl[i].e_req) check($sformatf("row%0d_addr", i), m0_addr, tbl[i].e_addr);
         if (tbl[i].chk_dat) begin
            check($sformatf("row%0d_instr", i), instr, tbl[i].e_instr);
            check($sformatf("row%0d_ipc", i), instr_pc, tbl[i].e_ipc);
         end
      end

      // redirect on the second cycle of a 4-cycle memory wait
      lat = 4; instr_ready = 1'b1;
      do_reset(); #1;
      check("rw_req0", m0_req, 1);
      tick(); #1;
      check("rw_wait1_req", m0_req, 0);
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_en = 1'b0; lat = 1; #1;
      check("rw_drain_pc", pc_value, 32'h100);
      check("rw_drain_valid", instr_valid, 0);
      check("rw_drain_req", m0_req, 0);
      tick(); #1;
      check("rw_stale_req", m0_req, 0);
      tick(); #1;
      check("rw_new_req", m0_req, 1);
      check("rw_new_addr", m0_addr, 32'h100);
      wait_valid("rw", 10);
      check("rw_ipc", instr_pc, 32'h100);
      check("rw_instr", instr, 32'h1A0);

      // redirect in the same cycle the response arrives
      lat = 2;
      do_reset();
      tick();
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_en = 1'b0; lat = 1; #1;
      check("cv_valid", instr_valid, 0);
      check("cv_req", m0_req, 1);
      check("cv_addr", m0_addr, 32'h40);
      wait_valid("cv", 10);
      check("cv_ipc", instr_pc, 32'h40);
      check("cv_instr", instr, 32'hE0);

      // redirect in HOLD while the consumer is ready
      redirect_en = 1'b1; redirect_pc = 32'h80;
      tick();
      redirect_en = 1'b0; #1;
      check("ch_valid", instr_valid, 0);
      check("ch_req", m0_req, 1);
      check("ch_addr", m0_addr, 32'h80);
      wait_valid("ch", 10);
      check("ch_ipc", instr_pc, 32'h80);

      // reset in the middle of a fetch
      lat = 4;
      do_reset();
      tick();
      rst = 1'b1; lat = 1; #1;
      check("mr_req_in_rst", m0_req, 0);
      tick();
      rst = 1'b0; #1;
      check("mr_valid", instr_valid, 0);
      check("mr_pc", pc_value, 0);
      check("mr_req", m0_req, 1);
      check("mr_addr", m0_addr, 0);
      wait_valid("mr", 10);
      check("mr_ipc", instr_pc, 0);
      check("mr_instr", instr, 32'hA0);

      // PC wrap on the second instance
      lat = 1;
      do_reset(); #1;
      check("wr_req0", m1_req, 1);
      check("wr_addr0", m1_addr, 32'hFFFF_FFFF);
      n = 0;
      while (!w_instr_valid && n < 10) begin
         tick(); #1; n++;
      end
      check("wr_timeout", w_instr_valid, 1);
      check("wr_ipc", w_instr_pc, 32'hFFFF_FFFF);
      check("wr_instr", w_instr, 32'h9F);
      tick(); #1;
      check("wr_pc", w_pc_value, 0);
      check("wr_req1", m1_req, 1);
      check("wr_addr1", m1_addr, 0);

      // randomized traffic against a program-order model
      do_reset();
      rand_lat = 1'b1; spur_en = 1'b1;
      exp_pc = '0; prev_kill = 1'b1; accepted = 0;
      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom_range(0, 299) == 0);
         instr_ready = ($urandom_range(0, 3) != 0);
         redirect_en = ($urandom_range(0, 11) == 0);
         redirect_pc = $urandom;
         #1;
         check("rnd_pc", pc_value, exp_pc);
         if (prev_kill) check("rnd_killed_valid", instr_valid, 0);
         if (rst) check("rnd_req_in_rst", m0_req, 0);
         if (m0_req) begin
            check("rnd_req_addr", m0_addr, exp_pc);
            check("rnd_req_in_hold", instr_valid, 0);
         end
         if (!rst && !redirect_en && instr_valid && instr_ready) begin
            check("rnd_acc_ipc", instr_pc, exp_pc);
            check("rnd_acc_instr", instr, memf(exp_pc));
            exp_pc = exp_pc + 1;
            accepted++;
         end
         if (rst) exp_pc = '0;
         else if (redirect_en) exp_pc = redirect_pc;
         prev_kill = rst || redirect_en;
         tick();
      end
      check("rnd_progress", accepted > 100, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
